// File: rtl/imm_pkg.sv
// ============================================================================
// Module      : imm_pkg
// Description : RV32 opcode constants and immediate-format encoding for imm_gen_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_pkg;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_CSR = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
// Module      : imm_decode
// Description : Combinational RV32 immediate/format decoder, sign-extended to XLEN.
//               Macro IMM_GEN_ZICSR_EN enables the CSR (zimm) format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  logic [31:0] w_imm32;
  fmt_e        w_fmt;
  logic        w_illegal;

  always_comb begin
    w_imm32   = '0;
    w_fmt     = FMT_ILL;
    w_illegal = 1'b1;
    case (inst_i[6:0])
      c_OPC_OP: begin
        w_imm32   = 32'd4;
        w_fmt     = FMT_R;
        w_illegal = 1'b0;
      end
      c_OPC_LOAD, c_OPC_OPIMM, c_OPC_JALR: begin
        w_imm32   = {{20{inst_i[31]}}, inst_i[31:20]};
        w_fmt     = FMT_I;
        w_illegal = 1'b0;
      end
      c_OPC_STORE: begin
        w_imm32   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        w_fmt     = FMT_S;
        w_illegal = 1'b0;
      end
      c_OPC_BRANCH: begin
        w_imm32   = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        w_fmt     = FMT_B;
        w_illegal = 1'b0;
      end
      c_OPC_LUI, c_OPC_AUIPC: begin
        w_imm32   = {inst_i[31:12], 12'b0};
        w_fmt     = FMT_U;
        w_illegal = 1'b0;
      end
      c_OPC_JAL: begin
        w_imm32   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        w_fmt     = FMT_J;
        w_illegal = 1'b0;
      end
      c_OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        w_imm32   = {27'b0, inst_i[19:15]};
        w_fmt     = FMT_CSR;
        w_illegal = 1'b0;
`else
        w_imm32   = '0;
        w_fmt     = FMT_ILL;
        w_illegal = 1'b1;
`endif
      end
      default: begin
        w_imm32   = '0;
        w_fmt     = FMT_ILL;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Bit 31 of the 32-bit immediate is already the sign (zero for CSR zimm).
  assign imm_o     = XLEN'(signed'(w_imm32));
  assign fmt_o     = w_fmt;
  assign illegal_o = w_illegal;

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module      : imm_gen_pipe
// Description : Immediate generator with one output register plus a skid register.
//               Macro IMM_GEN_ZICSR_EN (in imm_decode) enables the CSR format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [TAG_W-1:0] tag_o
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t w_in;
  logic   w_in_fire;

  stage_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (inst_i),
    .imm_o     (w_in.imm),
    .fmt_o     (w_in.fmt),
    .illegal_o (w_in.illegal)
  );

  assign w_in.pc  = pc_i;
  assign w_in.tag = tag_i;

  // Ready is a direct flop output: the skid slot guarantees room for one more.
  assign in_ready_o = ~skid_valid_q;
  assign w_in_fire  = in_valid_i & ~skid_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready_i) begin
      // Output slot frees this edge; the older skid entry wins it.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (w_in_fire) begin
        out_d       = w_in;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_in_fire) begin
      skid_d       = w_in;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign imm_o       = out_q.imm;
  assign fmt_o       = out_q.fmt;
  assign illegal_o   = out_q.illegal;
  assign pc_o        = out_q.pc;
  assign tag_o       = out_q.tag;

endmodule

`default_nettype wire
